// File: rtl/armleocpu_axi2simple_burst_converter.sv
// AXI4 slave to single-beat simple bus bridge: serialises AW/W/B and AR/R bursts
// into one-address-at-a-time read/write pulses, with round-robin arbitration.
module armleocpu_axi2simple_burst_converter #(
  parameter int ADDR_WIDTH = 34,
  parameter int ID_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  localparam int DATA_STROBES = DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    axi_awvalid,
  output logic                    axi_awready,
  input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [7:0]              axi_awlen,
  input  logic [2:0]              axi_awsize,
  input  logic [1:0]              axi_awburst,
  input  logic [ID_WIDTH-1:0]     axi_awid,

  input  logic                    axi_wvalid,
  output logic                    axi_wready,
  input  logic [DATA_WIDTH-1:0]   axi_wdata,
  input  logic [DATA_STROBES-1:0] axi_wstrb,
  input  logic                    axi_wlast,

  output logic                    axi_bvalid,
  input  logic                    axi_bready,
  output logic [1:0]              axi_bresp,
  output logic [ID_WIDTH-1:0]     axi_bid,

  input  logic                    axi_arvalid,
  output logic                    axi_arready,
  input  logic [ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [7:0]              axi_arlen,
  input  logic [2:0]              axi_arsize,
  input  logic [1:0]              axi_arburst,
  input  logic [ID_WIDTH-1:0]     axi_arid,

  output logic                    axi_rvalid,
  input  logic                    axi_rready,
  output logic [1:0]              axi_rresp,
  output logic [DATA_WIDTH-1:0]   axi_rdata,
  output logic [ID_WIDTH-1:0]     axi_rid,
  output logic                    axi_rlast,

  input  logic                    address_error,
  input  logic                    write_error,
  output logic [ADDR_WIDTH-1:0]   address,
  output logic                    write,
  output logic                    read,
  output logic [DATA_WIDTH-1:0]   write_data,
  output logic [DATA_STROBES-1:0] write_byteenable,
  input  logic [DATA_WIDTH-1:0]   read_data,

  output logic [2:0]              o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WRITE_BEAT  = 3'd1,
    S_WRITE_RESP  = 3'd2,
    S_READ_ACCESS = 3'd3,
    S_READ_RESP   = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam int MAX_SIZE = $clog2(DATA_STROBES);

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_last_write;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [7:0]              r_len;
  logic [7:0]              r_cnt;
  logic [2:0]              r_size;
  logic [1:0]              r_burst;
  logic [ID_WIDTH-1:0]     r_id;
  logic [1:0]              r_resp;
  logic [1:0]              r_rresp;
  logic [DATA_WIDTH-1:0]   r_rdata;

  logic                    w_grant_write;
  logic                    w_grant_read;
  logic                    w_last_beat;
  logic [ADDR_WIDTH-1:0]   w_step;
  logic [ADDR_WIDTH-1:0]   w_wrap_mask;
  logic [ADDR_WIDTH-1:0]   w_incr_addr;
  logic [ADDR_WIDTH-1:0]   w_next_addr;
  logic                    w_wrap_len_ok;
  logic                    w_beat_err;
  logic [1:0]              w_wbeat_resp;
  logic [1:0]              w_resp_merged;
  logic [1:0]              w_rbeat_resp;

  // A valid/ready transfer happens on the rising edge where both are high; ready
  // here is derived combinationally from valid and state, valid is held until then.
  assign w_grant_write = axi_awvalid && (!axi_arvalid || !r_last_write);
  assign w_grant_read  = axi_arvalid && !w_grant_write;

  assign w_last_beat   = (r_cnt == r_len);
  assign w_step        = ADDR_WIDTH'(1) << r_size;
  assign w_incr_addr   = r_addr + w_step;
  assign w_wrap_mask   = ((ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1)) << r_size) - ADDR_WIDTH'(1);
  assign w_wrap_len_ok = (r_len == 8'd1) || (r_len == 8'd3) || (r_len == 8'd7) || (r_len == 8'd15);

  always_comb begin
    w_next_addr = r_addr;
    case (r_burst)
      BURST_FIXED: w_next_addr = r_addr;
      BURST_INCR:  w_next_addr = w_incr_addr;
      BURST_WRAP:  w_next_addr = (r_addr & ~w_wrap_mask) | (w_incr_addr & w_wrap_mask);
      default:     w_next_addr = r_addr;
    endcase
  end

  // Beats in error never reach the simple bus.
  assign w_beat_err = (r_burst == 2'b11)
                   || ((r_burst == BURST_WRAP) && !w_wrap_len_ok)
                   || (r_size > 3'(MAX_SIZE))
                   || ((r_addr & (w_step - ADDR_WIDTH'(1))) != '0);

  always_comb begin
    w_wbeat_resp = RESP_OKAY;
    if (w_beat_err)         w_wbeat_resp = RESP_SLVERR;
    else if (address_error) w_wbeat_resp = RESP_DECERR;
    else if (write_error)   w_wbeat_resp = RESP_SLVERR;
    if ((axi_wlast != w_last_beat) && (w_wbeat_resp == RESP_OKAY))
      w_wbeat_resp = RESP_SLVERR;
    w_resp_merged = (w_wbeat_resp > r_resp) ? w_wbeat_resp : r_resp;
    w_rbeat_resp = RESP_OKAY;
    if (w_beat_err)         w_rbeat_resp = RESP_SLVERR;
    else if (address_error) w_rbeat_resp = RESP_DECERR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_write)     w_state_next = S_WRITE_BEAT;
        else if (w_grant_read) w_state_next = S_READ_ACCESS;
      end
      S_WRITE_BEAT:  if (axi_wvalid && w_last_beat) w_state_next = S_WRITE_RESP;
      S_WRITE_RESP:  if (axi_bready) w_state_next = S_IDLE;
      S_READ_ACCESS: w_state_next = S_READ_RESP;
      S_READ_RESP:   if (axi_rready) w_state_next = w_last_beat ? S_IDLE : S_READ_ACCESS;
      default:       w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    axi_awready = 1'b0;
    axi_arready = 1'b0;
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
    axi_rvalid  = 1'b0;
    axi_rlast   = 1'b0;
    write       = 1'b0;
    read        = 1'b0;
    address     = axi_araddr;
    case (r_state)
      S_IDLE: begin
        axi_awready = w_grant_write;
        axi_arready = w_grant_read;
      end
      S_WRITE_BEAT: begin
        address    = r_addr;
        axi_wready = axi_wvalid;
        write      = axi_wvalid && !w_beat_err;
      end
      S_WRITE_RESP: axi_bvalid = 1'b1;
      S_READ_ACCESS: begin
        address = r_addr;
        read    = !w_beat_err;
      end
      S_READ_RESP: begin
        axi_rvalid = 1'b1;
        axi_rlast  = w_last_beat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_write <= 1'b0;
      r_addr       <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_size       <= '0;
      r_burst      <= '0;
      r_id         <= '0;
      r_resp       <= RESP_OKAY;
      r_rresp      <= RESP_OKAY;
      r_rdata      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_write) begin
            r_last_write <= 1'b1;
            r_addr       <= axi_awaddr;
            r_len        <= axi_awlen;
            r_size       <= axi_awsize;
            r_burst      <= axi_awburst;
            r_id         <= axi_awid;
            r_cnt        <= '0;
            r_resp       <= RESP_OKAY;
          end else if (w_grant_read) begin
            r_last_write <= 1'b0;
            r_addr       <= axi_araddr;
            r_len        <= axi_arlen;
            r_size       <= axi_arsize;
            r_burst      <= axi_arburst;
            r_id         <= axi_arid;
            r_cnt        <= '0;
          end
        end
        S_WRITE_BEAT: begin
          if (axi_wvalid) begin
            r_resp <= w_resp_merged;
            if (!w_last_beat) begin
              r_addr <= w_next_addr;
              r_cnt  <= r_cnt + 8'd1;
            end
          end
        end
        S_READ_ACCESS: begin
          r_rdata <= w_beat_err ? '0 : read_data;
          r_rresp <= w_rbeat_resp;
        end
        S_READ_RESP: begin
          if (axi_rready && !w_last_beat) begin
            r_addr <= w_next_addr;
            r_cnt  <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign axi_bresp        = r_resp;
  assign axi_bid          = r_id;
  assign axi_rid          = r_id;
  assign axi_rresp        = r_rresp;
  assign axi_rdata        = r_rdata;
  assign write_data       = axi_wdata;
  assign write_byteenable = axi_wstrb;
  assign o_dbg_state      = r_state;

endmodule

// File: doc/armleocpu_axi2simple_burst_converter.md
ARMLEOCPU_AXI2SIMPLE_BURST_CONVERTER -- requirements
Module: armleocpu_axi2simple_burst_converter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 34, the AXI and simple address width.
REQ-002 SHALL have parameter ID_WIDTH, default 4, the AXI ID width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, legal values 32 or 64; DATA_STROBES = DATA_WIDTH/8.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have AW ports: axi_awvalid in 1; axi_awready out 1; axi_awaddr in ADDR_WIDTH; axi_awlen in 8; axi_awsize in 3; axi_awburst in 2; axi_awid in ID_WIDTH.
REQ-007 SHALL have W ports: axi_wvalid in 1; axi_wready out 1; axi_wdata in DATA_WIDTH; axi_wstrb in DATA_STROBES; axi_wlast in 1.
REQ-008 SHALL have B ports: axi_bvalid out 1; axi_bready in 1; axi_bresp out 2; axi_bid out ID_WIDTH.
REQ-009 SHALL have AR ports: axi_arvalid, axi_arready, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arid, with the same widths as AW.
REQ-010 SHALL have R ports: axi_rvalid out 1; axi_rready in 1; axi_rresp out 2; axi_rdata out DATA_WIDTH; axi_rid out ID_WIDTH; axi_rlast out 1.
REQ-011 SHALL have simple ports:
- address_error in 1 and write_error in 1, both qualifying the current address.
- address out ADDR_WIDTH; write out 1; read out 1.
- write_data out DATA_WIDTH, equal to axi_wdata.
- write_byteenable out DATA_STROBES, equal to axi_wstrb.
- read_data in DATA_WIDTH, combinationally valid for address.

Function
REQ-012 SHALL use states IDLE, WRITE_BEAT, WRITE_RESP, READ_ACCESS, READ_RESP.
REQ-013 In IDLE, with both axi_awvalid and axi_arvalid high, SHALL grant round-robin against the last granted direction; write wins the first contention after reset.
REQ-014 On a grant SHALL assert the matching axi_awready or axi_arready for exactly one cycle and latch addr, len, size, burst and id.
- After a write grant, SHALL go to WRITE_BEAT.
- After a read grant, SHALL go to READ_ACCESS.
REQ-015 The beat counter SHALL count from 0 to len; a burst is len+1 beats.
REQ-016 The next beat address SHALL follow the burst type, with step = 2^size bytes:
- FIXED (00): address unchanged.
- INCR (01): address + step.
- WRAP (10): address + step, wrapping within an aligned window of (len+1)*step bytes.
REQ-017 A beat is in error, with no read/write pulse issued for it, if any of the following holds; its response is SLVERR (10):
- burst is 11;
- WRAP with len not in {1,3,7,15};
- 2^size > DATA_STROBES;
- address not aligned to step.
REQ-018 Otherwise, for a write beat: address_error gives DECERR (11); else write_error gives SLVERR; else OKAY. For a read beat: address_error gives DECERR; else OKAY.
REQ-019 In WRITE_BEAT, when axi_wvalid is high, SHALL in the same cycle:
- assert axi_wready;
- assert write (unless the beat is in error) with address = the current beat address;
- advance the counter.
REQ-020 Write completion and wlast handling:
- After beat len, SHALL move to WRITE_RESP.
- axi_wlast disagreeing with (counter == len) SHALL set SLVERR.
- The burst still ends at beat len.
REQ-021 axi_bresp SHALL be the most severe response over all beats (DECERR > SLVERR > OKAY); axi_bid = latched awid.
REQ-022 In WRITE_RESP, axi_bvalid SHALL be held high; on axi_bready, return to IDLE.
REQ-023 In READ_ACCESS, SHALL for exactly one cycle:
- assert read (unless the beat is in error);
- register read_data into axi_rdata, or 0 if the beat is in error;
- register the beat response into axi_rresp;
- move to READ_RESP.
REQ-024 In READ_RESP, the R outputs SHALL be valid and held as follows:
- axi_rvalid is high.
- axi_rdata and axi_rresp are held stable.
- axi_rid = latched arid.
- axi_rlast = (counter == len).
REQ-025 On axi_rready in READ_RESP: if last, SHALL return to IDLE; else SHALL advance the address and counter and go to READ_ACCESS.
- Read throughput is one beat per two cycles minimum.
REQ-026 write and read SHALL never be asserted in the same cycle, and SHALL never be asserted outside WRITE_BEAT and READ_ACCESS respectively.
REQ-027 address SHALL equal the current beat address in WRITE_BEAT and READ_ACCESS, and axi_araddr otherwise.

Reset
REQ-028 While rst_n is low:
- state = IDLE, round-robin pointer = write.
- All valid, ready, read and write outputs are 0.
- axi_bresp, axi_rresp, axi_rdata, axi_bid, axi_rid and axi_rlast are 0.
REQ-029 Reset asserted mid-burst SHALL abandon the burst immediately, with no further beats or responses.

Verification
REQ-030 INCR write: awaddr=0x100, len=3, size=2, four W beats with wlast on the 4th -> write pulses at 0x100/0x104/0x108/0x10C; one B with bresp=00 and bid=awid.
REQ-031 WRAP read: araddr=0x38, len=3, size=2 -> read addresses 0x38, 0x3C, 0x30, 0x34; rlast only on the 4th beat.
REQ-032 Simultaneous AW and AR valid, twice back-to-back -> grants in order write, read, write, read.
REQ-033 Read of len=1 with address_error high on beat 1 only -> rresp 00 then 11; two R beats, rlast on the second.
REQ-034 Write with awaddr=0x102, size=2 -> no write pulse; W beats still consumed; bresp=10.
REQ-035 rst_n pulled low during READ_RESP of beat 2 of 4 -> axi_rvalid=0 immediately; IDLE after release; no stale R beat.
